// File: rtl/hf_tag_sim_mod.sv
// hf_tag_sim_mod: ISO 14443 tag simulator front end on the 13.56 MHz carrier.
// Hysteresis comparator (with low timeout) on the peak-detector ADC, a
// word-aligned SSP bit clock / frame to the ARM, and registered load
// modulation of the antenna drivers.
module hf_tag_sim_mod #(
    parameter int unsigned ADC_W      = 8,
    parameter int unsigned HYST_HI    = 224,
    parameter int unsigned HYST_LO    = 31,
    parameter int unsigned TMO_W      = 12,
    parameter int unsigned DIV_W      = 9,
    parameter int unsigned FRAME_BITS = 8,
    parameter bit          DEEP_MOD   = 1'b0
) (
    input  logic             ck_1356meg,
    input  logic             reset_n,
    input  logic [ADC_W-1:0] adc_d,
    input  logic [2:0]       mod_type,
    input  logic             ssp_dout,
    output logic             adc_clk,
    output logic             ssp_clk,
    output logic             ssp_frame,
    output logic             ssp_din,
    output logic             pwr_lo,
    output logic             pwr_hi,
    output logic             pwr_oe1,
    output logic             pwr_oe2,
    output logic             pwr_oe3,
    output logic             pwr_oe4,
    output logic             dbg
);

    localparam logic [2:0] MODE_BPSK     = 3'd1;
    localparam logic [2:0] MODE_OOK212   = 3'd2;
    localparam logic [2:0] MODE_OOK424   = 3'd3;
    localparam logic [2:0] MODE_OOK424_8 = 3'd4;
    localparam logic [2:0] MODE_MAN106   = 3'd5;
    localparam logic [2:0] MODE_CONST    = 3'd6;

    localparam int unsigned    CNT_W    = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);
    localparam logic [ADC_W-1:0] ADC_HI   = ADC_W'(HYST_HI);
    localparam logic [ADC_W-1:0] ADC_LO   = ADC_W'(HYST_LO);

    logic [DIV_W-1:0] r_div;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [TMO_W-1:0] r_tmo_cnt;
    logic             r_hyst;
    logic             r_mod_bit;
    logic [2:0]       r_mode_q;
    logic             r_ssp_clk;
    logic             r_ssp_frame;
    logic             r_ssp_din;
    logic             r_pwr_oe4;

    logic             w_div_k;
    logic             w_bit_stb;
    logic             w_mod;
    logic             w_mode_chg;

    assign w_mode_chg = (mod_type != r_mode_q);

    // Bit-rate select: divider tap driving ssp_clk and the strobe where its low bits wrap.
    always_comb begin
        w_div_k   = r_div[4];
        w_bit_stb = (r_div[4:0] == 5'd0);
        case (r_mode_q)
            MODE_OOK424_8: begin
                w_div_k   = r_div[7];
                w_bit_stb = (r_div[7:0] == 8'd0);
            end
            MODE_OOK212: begin
                w_div_k   = r_div[5];
                w_bit_stb = (r_div[5:0] == 6'd0);
            end
            MODE_MAN106: begin
                w_div_k   = r_div[6];
                w_bit_stb = (r_div[6:0] == 7'd0);
            end
            default: ;
        endcase
    end

    // Modulation waveform; registered into pwr_oe4 so the driver never glitches.
    always_comb begin
        w_mod = 1'b0;
        case (r_mode_q)
            MODE_BPSK:                  w_mod = r_mod_bit ^ r_div[3];
            MODE_OOK212:                w_mod = r_mod_bit & r_div[5];
            MODE_OOK424, MODE_OOK424_8: w_mod = r_mod_bit & r_div[4];
            // Logic 1: subcarrier in first half-bit; logic 0: in second half-bit.
            MODE_MAN106:                w_mod = r_div[3] & (r_mod_bit ? ~r_div[6] : r_div[6]);
            MODE_CONST:                 w_mod = 1'b1;
            default:                    w_mod = 1'b0;
        endcase
    end

    // Hysteresis comparator; a long low stretch forces the comparator set.
    always_ff @(posedge ck_1356meg) begin
        if (!reset_n) begin
            r_hyst    <= 1'b0;
            r_tmo_cnt <= '0;
        end else if (adc_d >= ADC_HI) begin
            r_hyst    <= 1'b1;
            r_tmo_cnt <= '0;
        end else if (r_tmo_cnt == {TMO_W{1'b1}}) begin
            // Timeout wins over a simultaneous clear.
            r_hyst    <= 1'b1;
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
            if (adc_d <= ADC_LO) begin
                r_hyst <= 1'b0;
            end
        end
    end

    // Divider, SSP bit/frame timing, data capture and the modulation register.
    always_ff @(posedge ck_1356meg) begin
        if (!reset_n) begin
            r_div       <= '0;
            r_bit_cnt   <= '0;
            r_mod_bit   <= 1'b0;
            r_mode_q    <= 3'd0;
            r_ssp_clk   <= 1'b0;
            r_ssp_frame <= 1'b0;
            r_ssp_din   <= 1'b0;
            r_pwr_oe4   <= 1'b0;
        end else begin
            r_ssp_clk <= ~w_div_k;
            if (w_mode_chg) begin
                // Restart the word cleanly in the new mode; drivers off for this cycle.
                r_mode_q    <= mod_type;
                r_div       <= '0;
                r_bit_cnt   <= '0;
                r_mod_bit   <= 1'b0;
                r_ssp_frame <= 1'b0;
                r_pwr_oe4   <= 1'b0;
            end else begin
                r_div     <= r_div + DIV_W'(1);
                r_pwr_oe4 <= w_mod;
                if (w_bit_stb) begin
                    r_ssp_din   <= r_hyst;
                    r_mod_bit   <= ssp_dout;
                    r_bit_cnt   <= (r_bit_cnt == LAST_BIT) ? '0 : r_bit_cnt + CNT_W'(1);
                    r_ssp_frame <= (r_bit_cnt == LAST_BIT);
                end
            end
        end
    end

    assign adc_clk   = ck_1356meg;
    assign ssp_clk   = r_ssp_clk;
    assign ssp_frame = r_ssp_frame;
    assign ssp_din   = r_ssp_din;
    assign pwr_lo    = 1'b0;
    assign pwr_hi    = 1'b0;
    assign pwr_oe2   = 1'b0;
    assign pwr_oe3   = 1'b0;
    assign pwr_oe4   = r_pwr_oe4;
    assign pwr_oe1   = DEEP_MOD ? r_pwr_oe4 : 1'b0;
    assign dbg       = r_ssp_frame;

endmodule

// File: tb/tb_hf_tag_sim_mod.sv
// Self-checking bench for hf_tag_sim_mod: random stimulus against a timeline model.
module tb_hf_tag_sim_mod;

    localparam int unsigned FB   = 8;
    localparam bit          DEEP = 1'b0;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic [7:0] adc_d    = 8'd0;
    logic [2:0] mod_type = 3'd0;
    logic       ssp_dout = 1'b0;
    logic adc_clk, ssp_clk, ssp_frame, ssp_din;
    logic pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3, pwr_oe4, dbg;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: cycles / bits since the last restart, plus comparator.
    int unsigned m_t, m_bits, m_tmo;
    logic [2:0]  m_mode;
    bit m_hyst, m_din, m_mbit, m_sclk, m_frame, m_oe4;

    always #5 clk = ~clk;

    hf_tag_sim_mod #(
        .ADC_W(8), .HYST_HI(224), .HYST_LO(31), .TMO_W(12), .DIV_W(9),
        .FRAME_BITS(FB), .DEEP_MOD(DEEP)
    ) dut (
        .ck_1356meg(clk), .reset_n(reset_n), .adc_d(adc_d), .mod_type(mod_type),
        .ssp_dout(ssp_dout), .adc_clk(adc_clk), .ssp_clk(ssp_clk), .ssp_frame(ssp_frame),
        .ssp_din(ssp_din), .pwr_lo(pwr_lo), .pwr_hi(pwr_hi), .pwr_oe1(pwr_oe1),
        .pwr_oe2(pwr_oe2), .pwr_oe3(pwr_oe3), .pwr_oe4(pwr_oe4), .dbg(dbg)
    );

    logic [9:0] obs, exp_v;
    assign obs   = {ssp_clk, ssp_frame, ssp_din, pwr_lo, pwr_hi, pwr_oe1, pwr_oe2, pwr_oe3,
                    pwr_oe4, dbg};
    assign exp_v = {m_sclk, m_frame, m_din, 1'b0, 1'b0, (DEEP ? m_oe4 : 1'b0), 1'b0, 1'b0,
                    m_oe4, m_frame};

    function automatic bit bitof(input int unsigned v, input int unsigned i);
        return ((v >> i) & 32'd1) != 0;
    endfunction

    // Advance the model by one carrier edge from the inputs present at that edge.
    task automatic model_update();
        int unsigned d, k;
        bit m, h_old;
        if (!reset_n) begin
            m_t = 0; m_bits = 0; m_tmo = 0; m_mode = 3'd0;
            m_hyst = 0; m_din = 0; m_mbit = 0; m_sclk = 0; m_frame = 0; m_oe4 = 0;
        end else begin
            d = m_t % 512;
            if (m_mode == 3'd4) k = 7;
            else if (m_mode == 3'd2) k = 5;
            else if (m_mode == 3'd5) k = 6;
            else k = 4;
            case (m_mode)
                3'd1:       m = m_mbit ^ bitof(d, 3);
                3'd2:       m = m_mbit & bitof(d, 5);
                3'd3, 3'd4: m = m_mbit & bitof(d, 4);
                3'd5:       m = bitof(d, 3) & (m_mbit ? !bitof(d, 6) : bitof(d, 6));
                3'd6:       m = 1'b1;
                default:    m = 1'b0;
            endcase
            h_old = m_hyst;
            if (adc_d >= 8'd224) begin
                m_hyst = 1; m_tmo = 0;
            end else if (m_tmo == 4095) begin
                m_hyst = 1; m_tmo = 0;
            end else begin
                m_tmo = m_tmo + 1;
                if (adc_d <= 8'd31) m_hyst = 0;
            end
            m_sclk = !bitof(d, k);
            if (mod_type != m_mode) begin
                m_mode = mod_type; m_t = 0; m_bits = 0; m_mbit = 0; m_frame = 0; m_oe4 = 0;
            end else begin
                m_t = m_t + 1;
                m_oe4 = m;
                if ((d % (32'd1 << (k + 1))) == 0) begin
                    m_din  = h_old;
                    m_mbit = ssp_dout;
                    m_bits = m_bits + 1;
                    m_frame = (m_bits % FB) == 0;
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 0; adc_d = 8'd255; mod_type = 3'd6; ssp_dout = 1;
        @(posedge clk); #1;
        n_cmp++;
        if (adc_clk !== 1'b1) begin n_bad++; $display("FAIL adc_clk_high: got %b want 1", adc_clk); end
        @(negedge clk);
        n_cmp++;
        if (adc_clk !== 1'b0) begin n_bad++; $display("FAIL adc_clk_low: got %b want 0", adc_clk); end
        repeat (3) begin
            step();
            n_cmp++;
            if (obs !== 10'b0) begin n_bad++; $display("FAIL reset_outputs: got %b want 0", obs); end
        end
        n_cmp++;
        if (dut.r_div !== '0 || dut.r_bit_cnt !== '0 || dut.r_tmo_cnt !== '0 ||
            dut.r_hyst !== 1'b0 || dut.r_mod_bit !== 1'b0 || dut.r_mode_q !== 3'd0) begin
            n_bad++;
            $display("FAIL reset_state: div=%0d bit_cnt=%0d tmo=%0d hyst=%b mbit=%b mode=%0d want all 0",
                     dut.r_div, dut.r_bit_cnt, dut.r_tmo_cnt, dut.r_hyst, dut.r_mod_bit, dut.r_mode_q);
        end
        reset_n = 1;
        step();
        n_cmp++;
        if (pwr_oe4 !== 1'b0) begin n_bad++; $display("FAIL release_edge1_oe4: got %b want 0", pwr_oe4); end
        step();
        n_cmp++;
        if (pwr_oe4 !== 1'b1) begin n_bad++; $display("FAIL release_edge2_oe4: got %b want 1", pwr_oe4); end
        n_cmp++;
        if (obs !== exp_v) begin n_bad++; $display("FAIL release_outputs: got %b want %b", obs, exp_v); end
    endtask

    task automatic test_hysteresis();
        logic [7:0] seq [5];
        bit         hexp [5];
        seq  = '{8'd230, 8'd100, 8'd31, 8'd100, 8'd224};
        hexp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        mod_type = 3'd3; adc_d = 8'd100;
        step(); step();
        for (int i = 0; i < 5; i++) begin
            adc_d = seq[i];
            step();
            n_cmp++;
            if (dut.r_hyst !== hexp[i]) begin
                n_bad++;
                $display("FAIL hyst_seq[%0d]: adc=%0d got %b want %b", i, seq[i], dut.r_hyst, hexp[i]);
            end
        end
        repeat (40) begin
            step();
            n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL hyst_outputs: got %b want %b", obs, exp_v); end
        end
        n_cmp++;
        if (ssp_din !== 1'b1) begin n_bad++; $display("FAIL hyst_din: got %b want 1", ssp_din); end
    endtask

    task automatic test_timeout();
        adc_d = 8'd230;
        step();
        n_cmp++;
        if (dut.r_hyst !== 1'b1 || dut.r_tmo_cnt !== 12'd0) begin
            n_bad++; $display("FAIL tmo_arm: hyst=%b tmo=%0d want 1/0", dut.r_hyst, dut.r_tmo_cnt);
        end
        adc_d = 8'd20;
        repeat (4095) begin
            ssp_dout = 1'($urandom);
            step();
            n_cmp++;
            if (obs !== exp_v || dut.r_hyst !== m_hyst || dut.r_tmo_cnt !== 12'(m_tmo)) begin
                n_bad++;
                $display("FAIL tmo_cycle: got %b/%b/%0d want %b/%b/%0d", obs, dut.r_hyst,
                         dut.r_tmo_cnt, exp_v, m_hyst, m_tmo);
            end
        end
        n_cmp++;
        if (dut.r_hyst !== 1'b0 || dut.r_tmo_cnt !== 12'd4095) begin
            n_bad++; $display("FAIL tmo_before: hyst=%b tmo=%0d want 0/4095", dut.r_hyst, dut.r_tmo_cnt);
        end
        step();
        n_cmp++;
        if (dut.r_hyst !== 1'b1 || dut.r_tmo_cnt !== 12'd0) begin
            n_bad++; $display("FAIL tmo_force: hyst=%b tmo=%0d want 1/0", dut.r_hyst, dut.r_tmo_cnt);
        end
        step();
        n_cmp++;
        if (dut.r_hyst !== 1'b0 || dut.r_tmo_cnt !== 12'd1) begin
            n_bad++; $display("FAIL tmo_after: hyst=%b tmo=%0d want 0/1", dut.r_hyst, dut.r_tmo_cnt);
        end
    endtask

    task automatic test_framing();
        int sclk_hi, frame_hi, frame_rises, first_rise;
        bit prev_frame;
        sclk_hi = 0; frame_hi = 0; frame_rises = 0; first_rise = -1; prev_frame = 0;
        mod_type = 3'd0; step();
        mod_type = 3'd3; step();
        for (int j = 1; j <= 1024; j++) begin
            ssp_dout = 1'($urandom);
            adc_d = 8'($urandom);
            step();
            n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL frame_cycle %0d: got %b want %b", j, obs, exp_v); end
            if (ssp_clk === 1'b1) sclk_hi++;
            if (ssp_frame === 1'b1) frame_hi++;
            if (ssp_frame === 1'b1 && !prev_frame) begin
                frame_rises++;
                if (first_rise < 0) first_rise = j;
            end
            prev_frame = (ssp_frame === 1'b1);
        end
        n_cmp++;
        if (sclk_hi != 512) begin n_bad++; $display("FAIL frame_sclk_duty: got %0d want 512", sclk_hi); end
        n_cmp++;
        if (frame_hi != 128) begin n_bad++; $display("FAIL frame_high_cycles: got %0d want 128", frame_hi); end
        n_cmp++;
        if (frame_rises != 4) begin n_bad++; $display("FAIL frame_rises: got %0d want 4", frame_rises); end
        n_cmp++;
        if (first_rise != 225) begin n_bad++; $display("FAIL frame_first_rise: got %0d want 225", first_rise); end
    endtask

    task automatic test_manchester();
        int hi [4];
        hi = '{0, 0, 0, 0};
        ssp_dout = 1; mod_type = 3'd5;
        step();
        for (int j = 1; j <= 257; j++) begin
            step();
            if (j == 1) ssp_dout = 0;
            n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL manch_cycle %0d: got %b want %b", j, obs, exp_v); end
            if (j >= 2 && pwr_oe4 === 1'b1) hi[(j - 2) / 64]++;
        end
        n_cmp++;
        if (hi[0] != 32 || hi[1] != 0) begin
            n_bad++; $display("FAIL manch_bit1: halves %0d/%0d want 32/0", hi[0], hi[1]);
        end
        n_cmp++;
        if (hi[2] != 0 || hi[3] != 32) begin
            n_bad++; $display("FAIL manch_bit0: halves %0d/%0d want 0/32", hi[2], hi[3]);
        end
        repeat (512) begin
            ssp_dout = 1'($urandom);
            step();
            n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL manch_rand: got %b want %b", obs, exp_v); end
        end
    endtask

    task automatic test_mode_change();
        int guard, agree1, agree2;
        bit found;
        ssp_dout = 1; mod_type = 3'd3;
        step();
        found = 0; guard = 0;
        while (!found && guard < 400) begin
            step();
            guard++;
            if ((m_bits % FB) == 5 && (m_t % 32) == 10) found = 1;
        end
        n_cmp++;
        if (!found) begin n_bad++; $display("FAIL modechg_reach: got no bit 5 want bit 5 within 400"); end
        mod_type = 3'd2;
        step();
        n_cmp++;
        if (dut.r_div !== '0 || dut.r_bit_cnt !== '0 || pwr_oe4 !== 1'b0 || ssp_frame !== 1'b0) begin
            n_bad++;
            $display("FAIL modechg_clear: div=%0d bit_cnt=%0d oe4=%b frame=%b want all 0",
                     dut.r_div, dut.r_bit_cnt, pwr_oe4, ssp_frame);
        end
        repeat (1100) begin
            ssp_dout = 1'($urandom);
            adc_d = 8'($urandom);
            step();
            n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL modechg_cycle: got %b want %b", obs, exp_v); end
        end
        // BPSK: subcarrier phase follows the captured bit.
        ssp_dout = 0; mod_type = 3'd1;
        step();
        agree1 = 0; agree2 = 0;
        for (int j = 1; j <= 65; j++) begin
            step();
            if (j == 1) ssp_dout = 1;
            n_cmp++;
            if (obs !== exp_v) begin n_bad++; $display("FAIL bpsk_cycle %0d: got %b want %b", j, obs, exp_v); end
            if (j >= 2 && j <= 33 && pwr_oe4 === bitof(j - 1, 3)) agree1++;
            if (j >= 34 && pwr_oe4 === bitof(j - 1, 3)) agree2++;
        end
        n_cmp++;
        if (agree1 != 32 || agree2 != 0) begin
            n_bad++; $display("FAIL bpsk_phase: agree %0d/%0d want 32/0", agree1, agree2);
        end
    endtask

    task automatic test_random();
        int r;
        repeat (3000) begin
            r = int'($urandom_range(0, 3));
            if (r == 0) adc_d = 8'($urandom_range(224, 255));
            else if (r == 1) adc_d = 8'($urandom_range(0, 31));
            else adc_d = 8'($urandom_range(32, 223));
            ssp_dout = 1'($urandom);
            if ($urandom_range(0, 79) == 0) mod_type = 3'($urandom_range(0, 7));
            reset_n = ($urandom_range(0, 699) != 0);
            step();
            n_cmp++;
            if (obs !== exp_v || dut.r_hyst !== m_hyst || dut.r_tmo_cnt !== 12'(m_tmo)) begin
                n_bad++;
                $display("FAIL random_cycle: got %b/%b/%0d want %b/%b/%0d", obs, dut.r_hyst,
                         dut.r_tmo_cnt, exp_v, m_hyst, m_tmo);
            end
        end
        reset_n = 1;
    endtask

    initial begin
        test_reset();
        test_hysteresis();
        test_timeout();
        test_framing();
        test_manchester();
        test_mode_change();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
